// File: rtl/mem_ctrl.sv
// mem_ctrl: main-memory controller sitting between the icache/dcache miss
// ports and a synchronous single-port main-memory array.
//
// Only one block request is in flight at a time. The icache has priority when
// both caches request in the same cycle. A transaction accepted in cycle T:
//   T+1                  ISSUE : mem_en strobe (mem_we for dcache writes)
//   T+2 .. T+LAT-1       WAIT  : read data captured at the end of T+2
//   T+LAT                RESP  : one-cycle response to the owning cache
//   T+LAT+1              IDLE  : earliest next acceptance
//
// Ports:
//   clk, rst_aL                  clock, synchronous active-low reset
//   icache_req_*                 icache fill request (read only)
//   icache_resp_*                icache fill response
//   dcache_req_*                 dcache read/write request
//   dcache_resp_*                dcache read data / write acknowledge
//   mem_en, mem_we, mem_block_addr, mem_wr_data, mem_rd_data
//                                single-port memory interface; read data is
//                                valid the cycle after mem_en
module mem_ctrl #(
  parameter int BLOCK_ADDR_WIDTH = 29,
  parameter int BLOCK_DATA_WIDTH = 64,
  parameter int MEM_LATENCY      = 4
) (
  input  logic                        clk,
  input  logic                        rst_aL,
  // icache miss port
  input  logic                        icache_req_valid,
  output logic                        icache_req_ready,
  input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
  output logic                        icache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data,
  // dcache miss port
  input  logic                        dcache_req_valid,
  output logic                        dcache_req_ready,
  input  logic                        dcache_req_type,
  input  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] dcache_req_block_data,
  output logic                        dcache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] dcache_resp_block_data,
  // main memory
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [BLOCK_ADDR_WIDTH-1:0] mem_block_addr,
  output logic [BLOCK_DATA_WIDTH-1:0] mem_wr_data,
  input  logic [BLOCK_DATA_WIDTH-1:0] mem_rd_data
);

  // WAIT spans MEM_LATENCY-2 cycles; the counter starts at 0 on entry and the
  // FSM leaves WAIT when it reaches MEM_LATENCY-3.
  localparam int               CNT_W     = $clog2(MEM_LATENCY);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LATENCY - 3);

  localparam logic OWN_ICACHE = 1'b0;
  localparam logic OWN_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                      state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        owner_q;  // which cache owns the transaction
  logic                        we_q;     // dcache write
  logic [BLOCK_ADDR_WIDTH-1:0] addr_q;
  logic [BLOCK_DATA_WIDTH-1:0] data_q;   // write data, then captured read data

  logic in_idle, in_issue, in_resp;
  logic i_hs, d_hs;

  // Every output is qualified with rst_aL so a reset cycle is always silent,
  // whatever state the FSM happened to be in.
  assign in_idle  = rst_aL && (state_q == IDLE);
  assign in_issue = rst_aL && (state_q == ISSUE);
  assign in_resp  = rst_aL && (state_q == RESP);

  // icache wins a simultaneous request; dcache waits for an IDLE cycle in
  // which the icache is not asking.
  assign icache_req_ready = in_idle;
  assign dcache_req_ready = in_idle && !icache_req_valid;

  assign i_hs = icache_req_valid && icache_req_ready;
  assign d_hs = dcache_req_valid && dcache_req_ready;

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_hs) begin
            owner_q <= OWN_ICACHE;
            we_q    <= 1'b0;
            addr_q  <= icache_req_block_addr;
            data_q  <= '0;
            state_q <= ISSUE;
          end else if (d_hs) begin
            owner_q <= OWN_DCACHE;
            we_q    <= dcache_req_type;
            addr_q  <= dcache_req_block_addr;
            data_q  <= dcache_req_block_data;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Memory drives read data only in the cycle right after mem_en.
          if (cnt_q == '0 && !we_q) data_q <= mem_rd_data;
          if (cnt_q == WAIT_LAST) state_q <= RESP;
          else                    cnt_q   <= cnt_q + 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobe: exactly the ISSUE cycle.
  assign mem_en         = in_issue;
  assign mem_we         = in_issue && we_q;
  assign mem_block_addr = in_issue ? addr_q : '0;
  assign mem_wr_data    = (in_issue && we_q) ? data_q : '0;

  // Responses: data is zero whenever the matching valid is low; a dcache
  // write acknowledge carries zero data.
  assign icache_resp_valid      = in_resp && (owner_q == OWN_ICACHE);
  assign icache_resp_block_data = icache_resp_valid ? data_q : '0;
  assign dcache_resp_valid      = in_resp && (owner_q == OWN_DCACHE);
  assign dcache_resp_block_data = (dcache_resp_valid && !we_q) ? data_q : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  localparam int AW  = 29;
  localparam int DW  = 64;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_aL;
  logic          icache_req_valid, icache_req_ready;
  logic [AW-1:0] icache_req_block_addr;
  logic          icache_resp_valid;
  logic [DW-1:0] icache_resp_block_data;
  logic          dcache_req_valid, dcache_req_ready, dcache_req_type;
  logic [AW-1:0] dcache_req_block_addr;
  logic [DW-1:0] dcache_req_block_data;
  logic          dcache_resp_valid;
  logic [DW-1:0] dcache_resp_block_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_block_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;

  always #5 clk = ~clk;

  mem_ctrl #(.BLOCK_ADDR_WIDTH(AW), .BLOCK_DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_aL(rst_aL),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_block_addr(icache_req_block_addr),
    .icache_resp_valid(icache_resp_valid), .icache_resp_block_data(icache_resp_block_data),
    .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
    .dcache_req_type(dcache_req_type), .dcache_req_block_addr(dcache_req_block_addr),
    .dcache_req_block_data(dcache_req_block_data),
    .dcache_resp_valid(dcache_resp_valid), .dcache_resp_block_data(dcache_resp_block_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_block_addr(mem_block_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Contents of a block never written.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a, 3'b101, ~a, 3'b010};
  endfunction

  // Main memory array (environment): single port, read data valid only in
  // the cycle after the strobe, garbage otherwise.
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_arr[mem_block_addr] = mem_wr_data;
    if (mem_en && !mem_we)
      mem_rd_data <= mem_arr.exists(mem_block_addr) ? mem_arr[mem_block_addr] : init_val(mem_block_addr);
    else
      mem_rd_data <= {$urandom, $urandom};
  end

  // Reference model: architectural memory contents plus expected events.
  typedef struct { logic owner; logic [DW-1:0] data; int due; } resp_t;
  typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; int due; } mem_t;
  logic [DW-1:0] shadow [logic [AW-1:0]];
  resp_t resp_q[$];
  mem_t  mem_q[$];
  int    free_at = 0;  // first cycle a new request may be accepted
  logic  exp_ir;

  task automatic accept(input logic own, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    resp_t r;
    mem_t  m;
    m.addr = a; m.we = wr; m.wdata = d; m.due = cyc + 1;
    mem_q.push_back(m);
    r.owner = own; r.due = cyc + LAT;
    if (wr) begin
      shadow[a] = d;
      r.data = '0;
    end else begin
      r.data = shadow.exists(a) ? shadow[a] : init_val(a);
    end
    resp_q.push_back(r);
    free_at = cyc + LAT + 1;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin : mon
    resp_t r;
    mem_t  m;
    if (!rst_aL) begin
      chk("reset_ctrl_outs", {icache_req_ready, dcache_req_ready, icache_resp_valid,
                              dcache_resp_valid, mem_en, mem_we}, '0);
      chk("reset_data_outs", icache_resp_block_data | dcache_resp_block_data | mem_wr_data, '0);
      resp_q.delete();
      mem_q.delete();
      free_at = 0;
    end else begin
      exp_ir = (cyc >= free_at);
      chk("icache_req_ready", icache_req_ready, exp_ir);
      chk("dcache_req_ready", dcache_req_ready, exp_ir && !icache_req_valid);
      if (icache_req_valid && icache_req_ready)
        accept(1'b0, 1'b0, icache_req_block_addr, '0);
      else if (dcache_req_valid && dcache_req_ready)
        accept(1'b1, dcache_req_type, dcache_req_block_addr, dcache_req_block_data);

      if (mem_q.size() != 0 && mem_q[0].due < cyc) begin
        chk("mem_en_missing", cyc, mem_q[0].due);
        mem_q.delete(0);
      end
      if (resp_q.size() != 0 && resp_q[0].due < cyc) begin
        chk("resp_missing", cyc, resp_q[0].due);
        resp_q.delete(0);
      end

      if (mem_en) begin
        chk("mem_en_pending", mem_q.size(), 1);
        if (mem_q.size() != 0) begin
          m = mem_q.pop_front();
          chk("mem_en_cycle", cyc, m.due);
          chk("mem_block_addr", mem_block_addr, m.addr);
          chk("mem_we", mem_we, m.we);
          if (m.we) chk("mem_wr_data", mem_wr_data, m.wdata);
        end
      end

      if (icache_resp_valid || dcache_resp_valid) begin
        chk("resp_one_owner", icache_resp_valid && dcache_resp_valid, 0);
        chk("resp_pending", resp_q.size(), 1);
        if (resp_q.size() != 0) begin
          r = resp_q.pop_front();
          chk("resp_cycle", cyc, r.due);
          chk("resp_owner", dcache_resp_valid, r.owner);
          chk("resp_data", dcache_resp_valid ? dcache_resp_block_data : icache_resp_block_data, r.data);
        end
      end
      if (!icache_resp_valid) chk("iresp_data_idle", icache_resp_block_data, '0);
      if (!dcache_resp_valid) chk("dresp_data_idle", dcache_resp_block_data, '0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic icache_req(input logic [AW-1:0] a);
    int w = 0;
    icache_req_valid = 1'b1; icache_req_block_addr = a;
    @(negedge clk);
    while (!icache_req_ready && w < 400) begin @(negedge clk); w++; end
    if (!icache_req_ready) chk("icache_hs_timeout", w, 0);
    step();
    icache_req_valid = 1'b0; icache_req_block_addr = AW'($urandom);
  endtask

  task automatic dcache_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int w = 0;
    dcache_req_valid = 1'b1; dcache_req_type = wr;
    dcache_req_block_addr = a; dcache_req_block_data = d;
    @(negedge clk);
    while (!dcache_req_ready && w < 4000) begin @(negedge clk); w++; end
    if (!dcache_req_ready) chk("dcache_hs_timeout", w, 0);
    step();
    dcache_req_valid = 1'b0; dcache_req_block_data = {$urandom, $urandom};
  endtask

  initial begin
    // Reset with both caches requesting; icache 0x10, dcache read 0x30.
    rst_aL = 1'b0;
    icache_req_valid = 1'b1; icache_req_block_addr = AW'('h10);
    dcache_req_valid = 1'b1; dcache_req_type = 1'b0;
    dcache_req_block_addr = AW'('h30); dcache_req_block_data = '0;
    mem_arr[AW'('h10)] = 64'hDEADBEEF_CAFEF00D;
    shadow[AW'('h10)]  = 64'hDEADBEEF_CAFEF00D;
    repeat (2) @(posedge clk);
    #1 rst_aL = 1'b1;

    // Arbitration + icache fill + queued dcache read.
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0) chk("t1_iready_after_rst", icache_req_ready, 1);
      if (k <= 5) chk("t3_dready", dcache_req_ready, k == 5);
      if (k == 1) begin
        chk("t2_mem_en", mem_en, 1);
        chk("t2_mem_we", mem_we, 0);
        chk("t2_mem_addr", mem_block_addr, 'h10);
      end
      chk("t2_iresp_valid", icache_resp_valid, k == 4);
      if (k == 4) chk("t2_iresp_data", icache_resp_block_data, 64'hDEADBEEF_CAFEF00D);
      chk("t3_dresp_valid", dcache_resp_valid, k == 9);
      if (k == 9) chk("t3_dresp_data", dcache_resp_block_data, init_val(AW'('h30)));
      step();
      if (k == 0) icache_req_valid = 1'b0;
      if (k == 5) dcache_req_valid = 1'b0;
    end

    // dcache write then icache read-back.
    dcache_req_valid = 1'b1; dcache_req_type = 1'b1;
    dcache_req_block_addr = AW'('h20); dcache_req_block_data = 64'h0123456789ABCDEF;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0) chk("t4_dready", dcache_req_ready, 1);
      if (k == 1) begin
        chk("t4_mem_en", mem_en, 1);
        chk("t4_mem_we", mem_we, 1);
        chk("t4_mem_wr_data", mem_wr_data, 64'h0123456789ABCDEF);
      end
      if (k <= 4) chk("t4_dresp_valid", dcache_resp_valid, k == 4);
      if (k == 4) chk("t4_dresp_data", dcache_resp_block_data, 0);
      if (k == 9) begin
        chk("t4_readback_valid", icache_resp_valid, 1);
        chk("t4_readback_data", icache_resp_block_data, 64'h0123456789ABCDEF);
      end
      step();
      if (k == 0) dcache_req_valid = 1'b0;
      if (k == 4) begin icache_req_valid = 1'b1; icache_req_block_addr = AW'('h20); end
      if (k == 5) icache_req_valid = 1'b0;
    end

    // Reset during WAIT abandons the icache read.
    icache_req_valid = 1'b1; icache_req_block_addr = AW'('h7);
    @(negedge clk);
    chk("t5_hs", icache_req_ready, 1);
    step(); icache_req_valid = 1'b0;
    step(); rst_aL = 1'b0;
    step(); rst_aL = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) chk("t5_iready_after_rst", icache_req_ready, 1);
      chk("t5_no_iresp", icache_resp_valid, 0);
      step();
    end

    // Back-to-back icache traffic: one accept and one strobe per 5 cycles.
    icache_req_valid = 1'b1; icache_req_block_addr = AW'($urandom_range(0, 15));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t6_hs", icache_req_valid && icache_req_ready, (k % 5) == 0);
      chk("t6_mem_en", mem_en, (k % 5) == 1);
      step();
      if ((k % 5) == 0) icache_req_block_addr = AW'($urandom_range(0, 15));
    end
    icache_req_valid = 1'b0;
    repeat (5) step();

    // Randomized concurrent traffic on a small address range.
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 8)) step();
          icache_req(AW'($urandom_range(0, 15)));
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 4)) step();
          dcache_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), {$urandom, $urandom});
        end
      end
    join

    for (int w = 0; w < 50 && resp_q.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    chk("drain_resp_q", resp_q.size(), 0);
    chk("drain_mem_q", mem_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
